imem_responder: RTL and testbench
=================================

# imem_responder

Multi-cycle instruction/data memory responder that sits on the memory side of the fetch-stage request interface (Addr/Rd/Wr in, DataOut/Done/Stall/CacheHit/err out). It accepts one request at a time and completes reads and writes to a word-addressed storage array after a fixed latency. A single-entry line buffer returns repeat reads of the most recent address in one cycle. The block is the drop-in memory end for pipeline fetch and data-memory bench and integration work.

## Interface
- LATENCY, 4: cycles from request acceptance to Done on a buffer miss or write; legal range 2..15.
- AW, 8: word-address width; array depth is 2^AW 16-bit words, indexed by Addr[AW:1].
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-low (rst=0 at a rising edge resets the block).
- Addr  input  16  byte address; bit 0 must be 0.
- DataIn  input  16  write data, sampled at acceptance.
- Rd  input  1  read request.
- Wr  input  1  write request.
- DataOut  output  16  read data; registered, valid in the Done cycle, held until the next read completes.
- Done  output  1  one-cycle completion pulse.
- Stall  output  1  high while a multi-cycle access is in flight.
- CacheHit  output  1  high with Done when a read was served from the line buffer.
- err  output  1  high with Done for a rejected request.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: Rd and Wr are sampled. Nothing is requested -> stay in IDLE.
- Error check, taking precedence: (Rd & Wr) or Addr[0]=1.
  - Latch err=1, perform no array or buffer access, go to DONE.
- Read hit (buffer valid and tag == Addr[AW:1]): load buffer data into DataOut, set CacheHit, go to DONE.
- Read miss: latch the word index, load counter = LATENCY-1, go to BUSY.
  - On completion, DataOut and the buffer (tag, data, valid=1) take the array word.
- Write: latch index and DataIn, go to BUSY.
  - On completion, the array word is written.
  - If the buffer tag matches, buffer data is updated; otherwise the buffer is unchanged.
  - DataOut is unchanged.
- BUSY: counter decrements each cycle; at counter==1 the access completes and the next state is DONE.
- DONE: Done=1 for exactly one cycle, then IDLE. Rd/Wr are ignored in DONE and BUSY.
- Request inputs need only be valid in the acceptance cycle; later changes have no effect.
- The array is never reset. Contents survive rst.

## Timing
- Reset values: DataOut=0, Done=0, Stall=0, CacheHit=0, err=0, state IDLE, buffer valid=0, counter=0.
- Request accepted at edge ending cycle T (state IDLE, Rd|Wr=1).
- Hit or error: Done (with CacheHit or err) in cycle T+1; Stall stays 0.
- Miss or write: Stall=1 in cycles T+1..T+LATENCY-1; Done=1, Stall=0 in cycle T+LATENCY.
- Earliest next acceptance: cycle after Done. Back-to-back miss period is therefore LATENCY+1 cycles.
- CacheHit and err are 0 whenever Done=0.
- Reset mid-access (BUSY or DONE): return to IDLE next cycle.
  - A pending write is dropped: the array is not written.
  - No Done is produced.
  - The buffer is invalidated.
- Address wrap: Addr bits above AW are ignored. Aliases map to the same word and hit the buffer.

## Structure
- Shared package `imem_pkg`:
  - state enum (IDLE, BUSY, DONE);
  - default LATENCY/AW constants;
  - the 16-bit NOP word for bench use.
- Sub-module `imem_array`: synchronous-write, asynchronous-read 2^AW x 16 storage with no reset.
- The parent module holds the FSM, counter, request latches, line buffer and output registers.

## Test plan
- Reset then idle: rst=0 for 2 cycles, then Rd=Wr=0 for 10 cycles -> every output stays 0 and Done never pulses.
- Write then read miss: Wr Addr=0x0010 DataIn=0xBEEF at T -> Stall T+1..T+3, Done T+4.
  - Then Rd Addr=0x0010 -> Done 4 cycles later with DataOut=0xBEEF and CacheHit=0.
- Buffer hit: immediately repeat Rd 0x0010 -> Done next cycle, CacheHit=1, DataOut=0xBEEF, Stall never 1.
- Write-through buffer: Wr 0x0010=0x1234, then Rd 0x0010 -> hit with DataOut=0x1234.
- Errors:
  - Rd Addr=0x0011 -> Done+err next cycle, DataOut unchanged, no array change.
  - Rd=Wr=1 -> same err response.
- Reset mid-write: Wr 0x0020=0xAAAA, rst=0 at T+2 -> no Done; a later Rd 0x0020 returns the prior contents, and it is a miss.

Source files
------------

// File: rtl/imem_pkg.sv
// imem_pkg: shared definitions for the instruction/data memory responder.
//   state_t      - responder FSM states
//   DEF_LATENCY  - default miss/write latency in cycles (legal 2..15)
//   DEF_AW       - default word-address width (array depth 2^AW words)
//   NOP_WORD     - 16-bit NOP instruction word used to preload fetch memory
package imem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   localparam int unsigned DEF_LATENCY = 4;
   localparam int unsigned DEF_AW      = 8;
   localparam logic [15:0] NOP_WORD    = 16'hF000;

endpackage

// File: rtl/imem_array.sv
// imem_array: 2^AW x 16-bit word storage, synchronous write, asynchronous read.
// Deliberately has no reset so contents survive a block reset.
//   clk   in   clock
//   we    in   write enable
//   waddr in   write word index
//   wdata in   write data
//   raddr in   read word index
//   rdata out  read data (combinational)
module imem_array
   import imem_pkg::*;
#(
   parameter int unsigned AW = DEF_AW
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [15:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [15:0]   rdata
);

   logic [15:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/imem_responder.sv
// imem_responder: multi-cycle memory end of the fetch/data request interface.
// One request at a time; misses and writes complete after LATENCY cycles, a
// repeat read of the buffered word returns the next cycle.
//   clk      in   clock, rising edge
//   rst      in   synchronous active-low reset
//   Addr     in   byte address (bit 0 must be 0, bits above AW ignored)
//   DataIn   in   write data, sampled at acceptance
//   Rd / Wr  in   read / write request
//   DataOut  out  registered read data, held until the next read completes
//   Done     out  one-cycle completion pulse
//   Stall    out  high while a multi-cycle access is in flight
//   CacheHit out  with Done: read served from the line buffer
//   err      out  with Done: request rejected
module imem_responder
   import imem_pkg::*;
#(
   parameter int unsigned LATENCY = DEF_LATENCY,
   parameter int unsigned AW      = DEF_AW
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] Addr,
   input  logic [15:0] DataIn,
   input  logic        Rd,
   input  logic        Wr,
   output logic [15:0] DataOut,
   output logic        Done,
   output logic        Stall,
   output logic        CacheHit,
   output logic        err
);

   state_t        state, state_nxt;
   logic [3:0]    cnt, cnt_nxt;

   logic [AW-1:0] idx;
   logic [15:0]   wdata;
   logic          is_wr;

   logic          buf_valid;
   logic [AW-1:0] buf_tag;
   logic [15:0]   buf_data;

   logic          hit_flag;
   logic          err_flag;

   logic [AW-1:0] word;
   logic          req;
   logic          bad;
   logic          rd_hit;
   logic          complete;
   logic          arr_we;
   logic [15:0]   arr_rdata;

   assign word     = Addr[AW:1];
   assign req      = Rd | Wr;
   assign bad      = (Rd & Wr) | Addr[0];
   assign rd_hit   = Rd & ~bad & buf_valid & (buf_tag == word);
   assign complete = (state == BUSY) && (cnt == 4'd1);
   // Gated by rst so a reset landing on the completion edge drops the write.
   assign arr_we   = complete & is_wr & rst;

   if (AW < 15) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^Addr[15:AW+1];
   end

   imem_array #(.AW(AW)) u_array (
      .clk   (clk),
      .we    (arr_we),
      .waddr (idx),
      .wdata (wdata),
      .raddr (idx),
      .rdata (arr_rdata)
   );

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      Done      = 1'b0;
      Stall     = 1'b0;
      CacheHit  = 1'b0;
      err       = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               if (bad || rd_hit) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt = BUSY;
                  cnt_nxt   = 4'(LATENCY - 1);
               end
            end
         end
         BUSY: begin
            Stall   = 1'b1;
            cnt_nxt = cnt - 4'd1;
            if (cnt == 4'd1) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            Done      = 1'b1;
            CacheHit  = hit_flag;
            err       = err_flag;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         idx       <= '0;
         wdata     <= '0;
         is_wr     <= 1'b0;
         buf_valid <= 1'b0;
         buf_tag   <= '0;
         buf_data  <= '0;
         hit_flag  <= 1'b0;
         err_flag  <= 1'b0;
         DataOut   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (state == IDLE && req) begin
            hit_flag <= rd_hit;
            err_flag <= bad;
            idx      <= word;
            wdata    <= DataIn;
            is_wr    <= Wr;
            if (rd_hit) begin
               DataOut <= buf_data;
            end
         end
         if (complete) begin
            if (is_wr) begin
               // Write-through: keep the buffered copy coherent with the array.
               if (buf_tag == idx) begin
                  buf_data <= wdata;
               end
            end else begin
               DataOut   <= arr_rdata;
               buf_tag   <= idx;
               buf_data  <= arr_rdata;
               buf_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;
   import imem_pkg::*;

   localparam int unsigned LAT = 4;
   localparam int unsigned AW  = 8;

   logic        clk;
   logic        rst;
   logic [15:0] Addr;
   logic [15:0] DataIn;
   logic        Rd;
   logic        Wr;
   logic [15:0] DataOut;
   logic        Done;
   logic        Stall;
   logic        CacheHit;
   logic        err;

   imem_responder #(.LATENCY(LAT), .AW(AW)) dut (
      .clk      (clk),
      .rst      (rst),
      .Addr     (Addr),
      .DataIn   (DataIn),
      .Rd       (Rd),
      .Wr       (Wr),
      .DataOut  (DataOut),
      .Done     (Done),
      .Stall    (Stall),
      .CacheHit (CacheHit),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int unsigned acc_cyc;
      int unsigned done_cyc;
      bit          is_long;
      logic [15:0] data;
      bit          hit;
      bit          err;
   } exp_t;

   exp_t sbq[$];

   int n_checks = 0;
   int n_fail   = 0;
   bit mon_en   = 1'b0;

   // Reference model: word memory, single-entry buffer, last read data.
   logic [15:0] mem_m [int];
   bit          bv = 1'b0;
   int          btag = 0;
   logic [15:0] bdata = '0;
   logic [15:0] dout_m = '0;

   function automatic void check(string name, logic [31:0] act, logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endfunction

   // Monitor: pops the scoreboard whenever the DUT signals Done.
   always @(negedge clk) begin
      exp_t e;
      bit   exp_stall;
      if (mon_en) begin
         exp_stall = 1'b0;
         if (sbq.size() > 0) begin
            exp_stall = sbq[0].is_long && (cyc > sbq[0].acc_cyc) && (cyc < sbq[0].done_cyc);
         end
         check("stall", Stall, exp_stall);
         if (Done) begin
            if (sbq.size() == 0) begin
               check("done_without_request", Done, 0);
            end else begin
               e = sbq.pop_front();
               check("done_cycle", cyc, e.done_cyc);
               check("data_out", DataOut, e.data);
               check("cache_hit", CacheHit, e.hit);
               check("err", err, e.err);
            end
         end else begin
            check("cache_hit_idle", CacheHit, 0);
            check("err_idle", err, 0);
         end
      end
   end

   task automatic issue_nowait(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d);
      exp_t e;
      int   w;
      @(negedge clk);
      Rd = rd; Wr = wr; Addr = a; DataIn = d;
      e.acc_cyc = cyc;
      e.hit = 1'b0;
      e.err = 1'b0;
      if ((rd && wr) || a[0]) begin
         e.err = 1'b1;
         e.is_long = 1'b0;
         e.data = dout_m;
      end else begin
         w = int'(a[AW:1]);
         if (rd) begin
            if (bv && btag == w) begin
               e.hit = 1'b1;
               e.is_long = 1'b0;
               e.data = bdata;
            end else begin
               e.is_long = 1'b1;
               e.data = mem_m.exists(w) ? mem_m[w] : 16'h0000;
               bv = 1'b1;
               btag = w;
               bdata = e.data;
            end
            dout_m = e.data;
         end else begin
            e.is_long = 1'b1;
            mem_m[w] = d;
            if (bv && btag == w) bdata = d;
            e.data = dout_m;
         end
      end
      e.done_cyc = e.acc_cyc + (e.is_long ? LAT : 1);
      sbq.push_back(e);
      @(posedge clk);
      #1;
      // Scramble request inputs after acceptance; they must have no effect.
      Rd = 1'b0; Wr = 1'b0;
      Addr = 16'($urandom);
      DataIn = 16'($urandom);
   endtask

   task automatic wait_done();
      int b;
      b = 0;
      while (sbq.size() > 0 && b < 40) begin
         @(negedge clk);
         b++;
      end
      if (b >= 40) begin
         check("done_timeout", sbq.size(), 0);
         sbq.delete();
      end
   endtask

   task automatic issue(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d);
      issue_nowait(rd, wr, a, d);
      wait_done();
   endtask

   task automatic apply_reset(input int n);
      @(negedge clk);
      rst = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      sbq.delete();
      bv = 1'b0;
      dout_m = '0;
      mon_en = 1'b1;
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          pool [6];
      int          w;
      int unsigned r;
      logic [15:0] a;
      logic [15:0] saved;

      pool = '{8, 9, 16, 17, 100, 255};
      rst = 1'b0; Rd = 1'b0; Wr = 1'b0; Addr = '0; DataIn = '0;

      // Reset, then idle: monitor sees no Done, no Stall.
      apply_reset(2);
      repeat (10) @(negedge clk);
      check("reset_data_out", DataOut, 16'h0000);
      check("reset_done", Done, 0);

      // Write, read miss, buffer hit, write-through, hit.
      issue(0, 1, 16'h0010, 16'hBEEF);
      issue(1, 0, 16'h0010, 16'h0000);
      issue(1, 0, 16'h0010, 16'h0000);
      issue(0, 1, 16'h0010, 16'h1234);
      issue(1, 0, 16'h0010, 16'h0000);
      // Alias of word 8 (upper bits ignored) hits the buffer.
      issue(1, 0, 16'h0210, 16'h0000);

      // Errors: odd address, Rd & Wr together.
      issue(1, 0, 16'h0011, 16'h0000);
      issue(1, 1, 16'h0010, 16'h5555);
      issue(0, 1, 16'h0013, 16'h6666);
      issue(1, 0, 16'h0010, 16'h0000);

      // Reset in the middle of a write: write dropped, no Done.
      issue(0, 1, 16'h0020, NOP_WORD);
      saved = mem_m[16];
      issue_nowait(0, 1, 16'h0020, 16'hAAAA);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      sbq.delete();
      mem_m[16] = saved;
      bv = 1'b0;
      dout_m = '0;
      @(negedge clk);
      rst = 1'b1;
      repeat (6) @(negedge clk);
      check("post_reset_data_out", DataOut, 16'h0000);
      issue(1, 0, 16'h0020, 16'h0000);

      // Preload the random pool, then randomized traffic.
      foreach (pool[i]) begin
         issue(0, 1, 16'(pool[i] << 1), 16'($urandom));
      end
      for (int n = 0; n < 300; n++) begin
         w = pool[$urandom_range(0, 5)];
         a = 16'(($urandom_range(0, 127) << (AW + 1)) | (w << 1));
         r = $urandom_range(0, 9);
         if (r <= 4)      issue(1, 0, a, 16'($urandom));
         else if (r <= 7) issue(0, 1, a, 16'($urandom));
         else if (r == 8) issue($urandom_range(0, 1) == 1, 1'b1 ^ 1'b0 & 1'b0, a | 16'h0001, 16'($urandom));
         else             issue(1, 1, a, 16'($urandom));
      end

      repeat (4) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
